// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state encoding and default widths for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT      = 32;
    localparam int DATA_W_DEFAULT      = 32;
    localparam int MAX_DSTREAK_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Fetch/memory-stage arbiter for a single-ported unified memory,
//            M priority with bounded starvation of F.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iRdata,
    output logic              iReady,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic [DATA_W-1:0] dRdata,
    output logic              dReady,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck
);

    localparam int                  STREAK_W   = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    arb_state_t          state;
    arb_state_t          next_state;
    logic                grant_i;
    logic                grant_d;
    logic [STREAK_W-1:0] streak;

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                // F wins a contested slot only once M has used up its streak
                if (dReq && iReq && (streak == STREAK_MAX)) begin
                    next_state = IBUSY;
                    grant_i    = 1'b1;
                end else if (dReq) begin
                    next_state = DBUSY;
                    grant_d    = 1'b1;
                end else if (iReq) begin
                    next_state = IBUSY;
                    grant_i    = 1'b1;
                end
            end
            IBUSY:   if (memAck) next_state = IRESP;
            DBUSY:   if (memAck) next_state = DRESP;
            IRESP:   next_state = IDLE;
            DRESP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            streak   <= '0;
            memAddr  <= '0;
            memWdata <= '0;
            memWe    <= 1'b0;
            iRdata   <= '0;
            dRdata   <= '0;
        end else begin
            state <= next_state;
            if (grant_i) begin
                memAddr <= iAddr;
                memWe   <= 1'b0;
                streak  <= '0;
            end
            if (grant_d) begin
                memAddr  <= dAddr;
                memWdata <= dWdata;
                memWe    <= dWe;
                if (!iReq)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + STREAK_W'(1);
            end
            if ((state == IBUSY) && memAck)
                iRdata <= memRdata;
            if ((state == DBUSY) && memAck)
                dRdata <= memRdata;
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them
    assign memReq = (state == IBUSY) || (state == DBUSY);
    assign iReady = (state == IRESP);
    assign dReady = (state == DRESP);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iReq = 1'b0;
    logic [31:0] iAddr = '0;
    logic [31:0] iRdata;
    logic        iReady;
    logic        dReq = 1'b0;
    logic        dWe = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic [31:0] dRdata;
    logic        dReady;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata = '0;
    logic        memAck = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iReady(iReady),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dReady(dReady),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
        chk("ready_exclusive", {31'd0, iReady & dReady}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_memReq"},   {31'd0, memReq}, 32'd0);
        chk({tag, "_memWe"},    {31'd0, memWe},  32'd0);
        chk({tag, "_memAddr"},  memAddr,  32'd0);
        chk({tag, "_memWdata"}, memWdata, 32'd0);
        chk({tag, "_iRdata"},   iRdata,   32'd0);
        chk({tag, "_dRdata"},   dRdata,   32'd0);
        chk({tag, "_iReady"},   {31'd0, iReady}, 32'd0);
        chk({tag, "_dReady"},   {31'd0, dReady}, 32'd0);
    endtask

    logic [31:0] exp_addr [6];
    int          n;

    initial begin
        // Reset state
        #2;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b1;
        step();

        // F read only, ack at cycle 3
        iReq = 1'b1; iAddr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("fread_memReq", {31'd0, memReq}, 32'd1);
            chk("fread_memAddr", memAddr, 32'h100);
            chk("fread_memWe", {31'd0, memWe}, 32'd0);
            if (c == 3) begin memAck = 1'b1; memRdata = 32'h00500093; end
        end
        step();
        memAck = 1'b0; iReq = 1'b0;
        chk("fread_iReady", {31'd0, iReady}, 32'd1);
        chk("fread_iRdata", iRdata, 32'h00500093);
        chk("fread_memReq_resp", {31'd0, memReq}, 32'd0);
        step();
        chk("fread_idle", {29'd0, dut.state}, {29'd0, IDLE});
        chk("fread_iReady_off", {31'd0, iReady}, 32'd0);

        // Simultaneous F and M: M store first, F in the following IDLE
        iReq = 1'b1; iAddr = 32'h300;
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h2000; dWdata = 32'hDEADBEEF;
        step();
        chk("sim_memReq", {31'd0, memReq}, 32'd1);
        chk("sim_memWe", {31'd0, memWe}, 32'd1);
        chk("sim_memAddr", memAddr, 32'h2000);
        chk("sim_memWdata", memWdata, 32'hDEADBEEF);
        memAck = 1'b1;
        step();
        memAck = 1'b0; dReq = 1'b0;
        chk("sim_dReady", {31'd0, dReady}, 32'd1);
        step();
        chk("sim_idle_memReq", {31'd0, memReq}, 32'd0);
        step();
        chk("sim_f_memReq", {31'd0, memReq}, 32'd1);
        chk("sim_f_memAddr", memAddr, 32'h300);
        chk("sim_f_memWe", {31'd0, memWe}, 32'd0);
        memAck = 1'b1; memRdata = 32'h00000513;
        step();
        memAck = 1'b0; iReq = 1'b0;
        chk("sim_f_iReady", {31'd0, iReady}, 32'd1);
        chk("sim_f_iRdata", iRdata, 32'h00000513);
        step();

        // Starvation bound with MAX_DSTREAK=4 and immediate acks
        exp_addr = '{32'h600, 32'h600, 32'h600, 32'h600, 32'h500, 32'h600};
        iReq = 1'b1; iAddr = 32'h500;
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h600;
        memAck = 1'b1; memRdata = 32'h13579BDF;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!memReq && n < 10);
            chk("starve_grant_timeout", {31'd0, (n < 10)}, 32'd1);
            chk($sformatf("starve_grant%0d", g), memAddr, exp_addr[g]);
            if (g == 4) begin
                step();
                chk("starve_iReady", {31'd0, iReady}, 32'd1);
                chk("starve_iRdata", iRdata, 32'h13579BDF);
            end
        end
        step();
        dReq = 1'b0; iReq = 1'b0; memAck = 1'b0;
        step();
        step();

        // Late ack, then a spurious ack in IDLE
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("late_memReq", {31'd0, memReq}, 32'd1);
            chk("late_memAddr", memAddr, 32'h40);
            if (c == 6) begin memAck = 1'b1; memRdata = 32'hCAFE0040; end
        end
        step();
        memAck = 1'b0; dReq = 1'b0;
        chk("late_dReady", {31'd0, dReady}, 32'd1);
        chk("late_dRdata", dRdata, 32'hCAFE0040);
        step();
        memAck = 1'b1; memRdata = 32'h11111111;
        step();
        memAck = 1'b0;
        chk("spur_dReady", {31'd0, dReady}, 32'd0);
        chk("spur_iReady", {31'd0, iReady}, 32'd0);
        chk("spur_memReq", {31'd0, memReq}, 32'd0);
        chk("spur_dRdata", dRdata, 32'hCAFE0040);

        // Reset mid-access
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h80; dWdata = 32'h12345678;
        step();
        chk("rstmid_busy", {31'd0, memReq}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk_all_zero("rstmid");
        dReq = 1'b0;
        step();
        rst = 1'b1;
        memAck = 1'b1; memRdata = 32'h22222222;
        step();
        memAck = 1'b0;
        chk("rstack_memReq", {31'd0, memReq}, 32'd0);
        chk("rstack_dReady", {31'd0, dReady}, 32'd0);
        chk("rstack_dRdata", dRdata, 32'd0);
        iReq = 1'b1; iAddr = 32'h0;
        step();
        chk("rstf_memReq", {31'd0, memReq}, 32'd1);
        chk("rstf_memAddr", memAddr, 32'h0);
        memAck = 1'b1; memRdata = 32'h0000ABCD;
        step();
        memAck = 1'b0; iReq = 1'b0;
        chk("rstf_iReady", {31'd0, iReady}, 32'd1);
        chk("rstf_iRdata", iRdata, 32'h0000ABCD);
        step();

        // dReq held through DRESP: no grant there, new grant from IDLE
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h44;
        step();
        memAck = 1'b1; memRdata = 32'h44444444;
        step();
        memAck = 1'b0;
        chk("hold_dReady", {31'd0, dReady}, 32'd1);
        chk("hold_resp_memReq", {31'd0, memReq}, 32'd0);
        dAddr = 32'h48;
        step();
        chk("hold_idle_memReq", {31'd0, memReq}, 32'd0);
        chk("hold_idle_dReady", {31'd0, dReady}, 32'd0);
        step();
        chk("hold_regrant_memReq", {31'd0, memReq}, 32'd1);
        chk("hold_regrant_memAddr", memAddr, 32'h48);
        memAck = 1'b1;
        step();
        memAck = 1'b0; dReq = 1'b0;
        chk("hold_second_dReady", {31'd0, dReady}, 32'd1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
